// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the round-robin mux arbiter: source index, FSM states and
// one-hot helper.
package mux_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(idx_t idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle for mux_rr_arbiter; the master side drives
// requests, data and ready, the slave side is the arbiter.
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 4
);

    logic [N_REQ-1:0] req;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [WIDTH-1:0] D3;
    logic             ready;
    logic [N_REQ-1:0] gnt;
    idx_t             sel;
    logic             en;
    logic [WIDTH-1:0] Y;
    logic             valid;
    logic [N_REQ-1:0] ack;

    modport master (
        output req, D0, D1, D2, D3, ready,
        input  gnt, sel, en, Y, valid, ack
    );

    modport slave (
        input  req, D0, D1, D2, D3, ready,
        output gnt, sel, en, Y, valid, ack
    );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping from the top index back to 0.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  idx_t             ptr_i,
    output logic             found_o,
    output idx_t             winner_o
);

    idx_t cand;

    always_comb begin
        found_o  = 1'b0;
        winner_o = ptr_i;
        cand     = ptr_i;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // idx_t arithmetic wraps 3 -> 0 naturally
            cand = ptr_i + idx_t'(i);
            if (!found_o && req_i[cand]) begin
                found_o  = 1'b1;
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux path; registers the selected word and
// hands it downstream over valid/ready with bounded bursts per grant.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input logic            clk,
    input logic            rst_n,
    mux_rr_arbiter_if.slave bus
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_t           state_q, state_d;
    idx_t             ptr_q, ptr_d;
    idx_t             sel_q, sel_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] y_q, y_d;

    logic [WIDTH-1:0] d_arr [N_REQ];
    logic             found;
    idx_t             winner;
    logic             xfer;
    logic             burst_more;

    assign d_arr[0] = bus.D0;
    assign d_arr[1] = bus.D1;
    assign d_arr[2] = bus.D2;
    assign d_arr[3] = bus.D3;

    rr_pick u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .found_o  (found),
        .winner_o (winner)
    );

    assign xfer       = valid_q & bus.ready;
    assign burst_more = int'(burst_q) < (MAX_BURST - 1);

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.en    = valid_q;
    assign bus.Y     = y_q;
    assign bus.valid = valid_q;
    assign bus.ack   = gnt_q & {N_REQ{xfer}};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        burst_d = burst_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = onehot(winner);
                    sel_d   = winner;
                    valid_d = 1'b1;
                    y_d     = d_arr[winner];
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Only an accepted word may be replaced; stalls hold everything
                if (xfer) begin
                    if (bus.req[sel_q] && burst_more) begin
                        y_d     = d_arr[sel_q];
                        burst_d = burst_q + BW'(1);
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        ptr_d   = sel_q + idx_t'(1);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            burst_q <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            burst_q <= burst_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares the 4-bit 4:1 mux output path among four requesters.
- Each requester N presents data on DN and raises req[N].
- The arbiter grants one requester and drives the mux select and enable (sel, en).
- It registers the selected word and delivers it downstream over a valid/ready handshake.
- Supports bounded bursts so one requester cannot starve the others.

Parameters:
WIDTH, 4, data width of D0..D3 and Y
MAX_BURST, 4, max consecutive transfers per grant (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request per source, bit N = source DN
D0  input  WIDTH  source 0 data
D1  input  WIDTH  source 1 data
D2  input  WIDTH  source 2 data
D3  input  WIDTH  source 3 data
ready  input  1  downstream accepts Y this cycle
gnt  output  4  one-hot grant, registered
sel  output  2  mux select (index of granted source), registered
en  output  1  mux enable, high while granted, registered
Y  output  WIDTH  registered selected data
valid  output  1  Y holds a word for downstream
ack  output  4  combinational transfer strobe: ack[N] = gnt[N] & valid & ready

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: gnt=0, sel=0, en=0, Y=0, valid=0, ptr=0, burst_cnt=0, state=IDLE. Assertion mid-transfer aborts immediately and drops the word.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Else pick the winner W: first set bit of req scanning from ptr upward, wrapping 3->0.
  - Next edge: gnt=onehot(W), sel=W, en=1, Y=DW, valid=1, burst_cnt=0, go to GRANT.
  - Latency: req high at edge k gives valid at edge k+1.
- GRANT, no transfer (valid & !ready):
  - Hold Y, gnt, sel and valid stable. No recapture.
- GRANT, transfer (valid & ready):
  - ack[W] pulses in the same cycle.
  - Continue condition: req[W]==1 in that cycle AND burst_cnt < MAX_BURST-1.
  - If continuing: Y<=DW, burst_cnt++, valid stays 1, stay in GRANT. This gives back-to-back transfers, one per cycle while ready is high.
  - Otherwise: gnt=0, en=0, valid=0, ptr<=(W+1) mod 4, go to IDLE.
- A requester ends its burst by deasserting req in its ack cycle.
- req[W] dropping before the accept cycle does not cancel the captured word; it is still delivered.
- Handoff inserts exactly one IDLE bubble cycle between grants.
- MAX_BURST=1: every grant is a single transfer, giving strict rotation among active requesters.
- Requests from non-granted sources are only evaluated in IDLE. Changes to D of non-granted sources have no effect.
- Invariants:
  - gnt is one-hot or zero.
  - valid==en; valid implies gnt!=0.
  - sel equals the index of the gnt bit whenever gnt!=0.
  - burst_cnt width is clog2(MAX_BURST), min 1.

Decomposition:
- Package mux_arb_pkg:
  - N_REQ=4.
  - typedef idx_t (2-bit source index).
  - enum state_t {IDLE, GRANT}.
  - function onehot(idx_t).
- Sub-module rr_pick: combinational; inputs req[3:0] and ptr; outputs found and idx_t winner. Reusable by other arbiters in the design.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, valid=0, Y=0. Release -> valid at the 1st edge, gnt=4'b0001, sel=0, Y=D0=4'b0001.
- Single transfer: D2=4'b0100, req=4'b0100, ready=1, req dropped in the ack cycle -> one ack[2] pulse, Y=4'b0100, then IDLE. ptr=3 is confirmed by a later req=4'b1001 granting source 3 first.
- Backpressure: grant source 1 (D1=4'b0010) with ready=0 for 5 cycles -> Y=4'b0010, valid=1 and gnt=4'b0010 stay stable. ready=1 -> ack[1] in that cycle.
- Burst limit: MAX_BURST=4, req=4'b0001 held, D0 changing 1,2,3,4,5 per cycle, ready=1 -> exactly 4 acks with Y=1,2,3,4, then one bubble cycle, then re-grant of source 0.
- Fairness: req=4'b1111 held, ready=1, MAX_BURST=1 -> grant order 0,1,2,3,0 with one bubble between grants, Y=D0,D1,D2,D3,D0.
- Async reset mid-burst: rst_n pulsed low between edges during GRANT -> outputs clear immediately without a clock edge. After release, the next grant starts from source 0.
